// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: fetch-controller bundle for instruction memory, decode and branch redirect
interface pc_fetch_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic imem_req, imem_ack, instr_valid, instr_ready, branch_taken;
  logic [DATA_WIDTH-1:0] imem_addr, imem_rdata, instr, instr_pc, branch_pc, imm_op, pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_pc, imm_op
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_pc, imm_op
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencing and single-outstanding instruction fetch with redirect drain
module pc_fetch_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int RESET_PC   = 0,
  parameter int PC_INC     = 4
) (
  input logic clk,
  input logic rst,
  pc_fetch_ctrl_if.master bus
);
  localparam logic [DATA_WIDTH-1:0] RST_PC = DATA_WIDTH'(RESET_PC);
  localparam logic [DATA_WIDTH-1:0] INC    = DATA_WIDTH'(PC_INC);
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HOLD} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] pc, pc_nx, addr, instr, instr_pc, target;
  logic take, br, ack;
  assign br     = bus.branch_taken;
  assign ack    = bus.imem_ack;
  assign target = bus.branch_pc + bus.imm_op;
  assign bus.imem_req    = (state == FETCH) || (state == DRAIN);
  assign bus.imem_addr   = addr;
  assign bus.instr_valid = state == HOLD;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.pc          = pc;
  // next state and next pc; a redirect always wins, stale acks are swallowed
  always_comb begin
    state_nx = state;
    pc_nx    = br ? target : pc;
    take     = 1'b0;
    case (state)
      BOOT:  state_nx = FETCH;
      FETCH: begin
        take     = ack && !br;
        pc_nx    = take ? pc + INC : pc_nx;
        state_nx = take ? HOLD : (br && !ack) ? DRAIN : FETCH;
      end
      DRAIN: state_nx = ack ? FETCH : DRAIN;
      HOLD:  state_nx = (br || bus.instr_ready) ? FETCH : HOLD;
      default: state_nx = BOOT;
    endcase
  end
  // state, pc, fetch address (only reloaded on entry to FETCH) and captured instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RST_PC;
      addr     <= RST_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state_nx == FETCH) addr <= pc_nx;
      if (take) begin
        instr    <= bus.imem_rdata;
        instr_pc <= pc;
      end
    end
  end
endmodule
